// File: rtl/dac_pkg.sv
// dac_pkg -- shared types and constants for the serial DAC driver.
//   state_t     : driver FSM states
//   FRAME_BITS  : serial frame length
//   CTRL_BITS   : control bits at the head of the frame
//   DATA_LSB    : bit position of the sample LSB inside the frame
//   make_frame  : assembles {ctrl, sample, zero pad}
package dac_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CTRL_BITS  = 4;
  localparam int DATA_LSB   = 4;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  function automatic logic [FRAME_BITS-1:0] make_frame(
    input logic [CTRL_BITS-1:0] ctrl,
    input logic [DATA_BITS-1:0] data
  );
    make_frame = {ctrl, data, {DATA_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// dac_sclk_gen -- half-period divider and serial clock toggle.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   run   : divider counts while high; when low the counter reloads and
//           sclk parks high
//   tick  : last clk cycle of the current half-period
//   sclk  : serial clock phase, toggles at the end of every half-period
module dac_sclk_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick,
  output logic sclk
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt  <= RELOAD;
      sclk <= 1'b1;
    end else if (cnt == 8'd0) begin
      cnt  <= RELOAD;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

  assign tick = run && (cnt == 8'd0);

endmodule

// File: rtl/dac_driver.sv
// dac_driver -- serialises 8-bit samples into 16-bit DAC frames
// ({CTRL_WORD, sample, 4'b0000}, MSB first, data changes on the falling
// serial clock edge so the DAC samples on the rising edge).
//   clk, rst            : system clock, synchronous active-high reset
//   in_data/in_valid/in_ready : sample input handshake
//   dac_cs, dac_clk, dac_dat  : serial DAC interface (cs active low,
//                               clk idles high)
//   busy                : FSM not in IDLE
//   frame_done          : one-cycle pulse on the first cs-high cycle
// Build option: DAC_DRIVER_HOLD_BUF_EN adds a one-entry hold buffer so a
// sample can be accepted while a frame is in flight and follows the
// inter-frame gap directly.
module dac_driver
  import dac_pkg::*;
#(
  parameter int                   CLK_DIV   = 1,
  parameter logic [CTRL_BITS-1:0] CTRL_WORD = 4'b0000,
  parameter int                   CS_GAP    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 dac_cs,
  output logic                 dac_clk,
  output logic                 dac_dat,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [3:0] GAP_LAST = 4'(CS_GAP - 1);
  localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

  state_t                  state, state_nxt;
  logic [FRAME_BITS-1:0]   sreg;
  logic [3:0]              bit_cnt;
  logic [3:0]              gap_cnt;
  logic                    run, tick, sclk;
  logic                    last_gap, bit_end;
  logic                    load;
  logic [DATA_BITS-1:0]    load_data;

  assign run      = (state == SETUP) || (state == SHIFT);
  assign last_gap = (state == GAP) && (gap_cnt == GAP_LAST);
  // end of a high half == end of one bit period
  assign bit_end  = (state == SHIFT) && tick && sclk;

  dac_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .tick (tick),
    .sclk (sclk)
  );

`ifdef DAC_DRIVER_HOLD_BUF_EN
  logic                 buf_full;
  logic [DATA_BITS-1:0] buf_data;
  logic                 accept, can_load;

  assign in_ready  = !buf_full;
  assign accept    = in_valid && in_ready;
  // IDLE and the last GAP cycle can start a frame immediately; a sample
  // arriving then goes straight to the shift register.
  assign can_load  = (state == IDLE) || last_gap;
  assign load      = can_load && (buf_full || accept);
  assign load_data = buf_full ? buf_data : in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else if (accept && !can_load) begin
      buf_full <= 1'b1;
      buf_data <= in_data;
    end else if (can_load && buf_full) begin
      buf_full <= 1'b0;
    end
  end
`else
  assign in_ready  = (state == IDLE);
  assign load      = in_valid && in_ready;
  assign load_data = in_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    dac_cs     = 1'b1;
    dac_clk    = 1'b1;
    dac_dat    = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (load) state_nxt = SETUP;
      end
      SETUP: begin
        dac_cs  = 1'b0;
        dac_dat = sreg[FRAME_BITS-1];
        if (tick) state_nxt = SHIFT;
      end
      SHIFT: begin
        dac_cs  = 1'b0;
        dac_clk = sclk;
        dac_dat = sreg[FRAME_BITS-1];
        if (bit_end && bit_cnt == BIT_LAST) state_nxt = GAP;
      end
      GAP: begin
        frame_done = (gap_cnt == 4'd0);
        if (last_gap) state_nxt = load ? SETUP : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      if (load) begin
        sreg    <= make_frame(CTRL_WORD, load_data);
        bit_cnt <= '0;
      end else if (bit_end) begin
        // shift on the falling edge so the next bit is stable for the rise
        sreg    <= {sreg[FRAME_BITS-2:0], 1'b0};
        bit_cnt <= (bit_cnt == BIT_LAST) ? 4'd0 : bit_cnt + 4'd1;
      end
      if (state == GAP && !last_gap) gap_cnt <= gap_cnt + 4'd1;
      else                           gap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_dac_driver.sv
// tb_dac_driver -- scoreboard bench: two driver instances
// (CLK_DIV=1/CTRL=0 and CLK_DIV=3/CTRL=9). Stimulus pushes hand-computed
// frames; a negedge monitor reassembles serial frames and checks them.
module tb_dac_driver;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  [2];
  logic [7:0] din  [2];
  logic       vld  [2];
  logic       rdy  [2];
  logic       cs   [2];
  logic       dck  [2];
  logic       dat  [2];
  logic       busy [2];
  logic       fd   [2];

  dac_driver #(.CLK_DIV(1), .CTRL_WORD(4'b0000), .CS_GAP(2)) dut0 (
    .clk(clk), .rst(rst[0]), .in_data(din[0]), .in_valid(vld[0]),
    .in_ready(rdy[0]), .dac_cs(cs[0]), .dac_clk(dck[0]), .dac_dat(dat[0]),
    .busy(busy[0]), .frame_done(fd[0]));

  dac_driver #(.CLK_DIV(3), .CTRL_WORD(4'b1001), .CS_GAP(2)) dut1 (
    .clk(clk), .rst(rst[1]), .in_data(din[1]), .in_valid(vld[1]),
    .in_ready(rdy[1]), .dac_cs(cs[1]), .dac_clk(dck[1]), .dac_dat(dat[1]),
    .busy(busy[1]), .frame_done(fd[1]));

  int          checks = 0;
  int          errors = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int          div_of [2] = '{1, 3};

  logic        pcs [2] = '{1'b1, 1'b1};
  logic        pck [2] = '{1'b1, 1'b1};
  logic        pdat[2] = '{1'b0, 1'b0};
  logic        pfd [2] = '{1'b0, 1'b0};
  logic [15:0] cap [2];
  int          nbits[2], lowcnt[2], lastrise[2];
  int          hicnt[2] = '{0, 0};
  int          cyc  [2] = '{0, 0};
  logic        perbad[2], stabad[2];
  logic        abort  [2] = '{1'b0, 1'b0};
  logic        chk_gap[2] = '{1'b0, 1'b0};
  logic        fdbad  [2] = '{1'b0, 1'b0};
  int          fd_cnt [2] = '{0, 0};
  int          exp_fd [2] = '{0, 0};
  int          exp_gap = 0;
  logic        acc_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int g);
    logic [15:0] e;
    cyc[g]++;
    if (fd[g] === 1'b1) begin
      fd_cnt[g]++;
      if (pfd[g] === 1'b1) fdbad[g] = 1'b1;
    end
    if (cs[g] === 1'b0) begin
      if (pcs[g] === 1'b1) begin
        if (chk_gap[g]) begin
          chk("cs_gap", hicnt[g], exp_gap);
          chk_gap[g] = 1'b0;
        end
        cap[g] = '0; nbits[g] = 0; lowcnt[g] = 0; lastrise[g] = -1;
        perbad[g] = 1'b0; stabad[g] = 1'b0;
      end
      lowcnt[g]++;
      if (pck[g] === 1'b0 && dck[g] === 1'b1) begin
        cap[g] = {cap[g][14:0], dat[g]};
        nbits[g]++;
        if (lastrise[g] >= 0 && cyc[g] - lastrise[g] != 2 * div_of[g]) perbad[g] = 1'b1;
        lastrise[g] = cyc[g];
      end
      if (pcs[g] === 1'b0 && pck[g] === 1'b1 && dck[g] === 1'b1 && dat[g] !== pdat[g])
        stabad[g] = 1'b1;
    end else begin
      if (pcs[g] === 1'b0) begin
        if (abort[g]) begin
          abort[g] = 1'b0;
        end else if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
          checks++; errors++;
          $display("FAIL unexpected_frame dut%0d: got %0h expected none", g, cap[g]);
        end else begin
          if (g == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk("frame_data", cap[g], e);
          chk("frame_bits", nbits[g], 16);
          chk("cs_low_cycles", lowcnt[g], 33 * div_of[g]);
          chk("sclk_period", perbad[g], 0);
          chk("dat_stable_clk_high", stabad[g], 0);
          chk("frame_done_at_end", fd[g], 1);
        end
        hicnt[g] = 0;
      end
      hicnt[g]++;
    end
    pcs[g] = cs[g]; pck[g] = dck[g]; pdat[g] = dat[g]; pfd[g] = fd[g];
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) mon(g);
  end

  task automatic send(input int g, input logic [7:0] d, input logic [15:0] e, input bit push);
    int n = 0;
    @(negedge clk);
    din[g] = d;
    vld[g] = 1'b1;
    while (rdy[g] !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (rdy[g] !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_timeout dut%0d: got in_ready=%b expected 1", g, rdy[g]);
      vld[g] = 1'b0;
      return;
    end
    acc_busy = busy[g];
    if (push) begin
      if (g == 0) q0.push_back(e);
      else        q1.push_back(e);
      exp_fd[g]++;
    end
    @(negedge clk);
    vld[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    @(negedge clk);
    while (busy[g] !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (busy[g] !== 1'b0) begin
      checks++; errors++;
      $display("FAIL idle_timeout dut%0d: got busy=%b expected 0", g, busy[g]);
    end
  endtask

  initial begin
    logic bad;
    int   n;
    rst = '{1'b1, 1'b1};
    vld = '{1'b0, 1'b0};
    din = '{8'h00, 8'h00};
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++)
      chk("reset_outputs", {cs[g], dck[g], dat[g], busy[g], fd[g], rdy[g]}, 6'b110001);
    rst = '{1'b0, 1'b0};

    // basic frames on both instances
    send(0, 8'hA5, 16'h0A50, 1);
    wait_idle(0);
    send(1, 8'h3C, 16'h93C0, 1);
    send(1, 8'hFF, 16'h9FF0, 1);
    wait_idle(1);

    // back-to-back; second sample offered while the first frame shifts
`ifdef DAC_DRIVER_HOLD_BUF_EN
    exp_gap = 2;
`else
    exp_gap = 3;
`endif
    send(0, 8'h01, 16'h0010, 1);
    @(negedge clk);
    chk_gap[0] = 1'b1;
    repeat (2) @(negedge clk);
    send(0, 8'hFF, 16'h0FF0, 1);
`ifdef DAC_DRIVER_HOLD_BUF_EN
    chk("accept_while_busy", acc_busy, 1);
`endif
    wait_idle(0);
    chk("gap_measured", chk_gap[0], 0);

    // sample held on in_valid during a frame
    send(0, 8'h0F, 16'h00F0, 1);
`ifdef DAC_DRIVER_HOLD_BUF_EN
    send(0, 8'h55, 16'h0550, 1);
`else
    din[0] = 8'h55;
    vld[0] = 1'b1;
    bad = 1'b0;
    n = 0;
    while (busy[0] === 1'b1 && n < 3000) begin
      if (rdy[0] !== 1'b0) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("ready_low_while_busy", bad, 0);
    chk("ready_in_idle", rdy[0], 1);
    q0.push_back(16'h0550);
    exp_fd[0]++;
    @(negedge clk);
    vld[0] = 1'b0;
`endif
    wait_idle(0);

    // reset during bit 7 of a frame; the truncated frame is dropped
    send(0, 8'h12, 16'h0000, 0);
    repeat (15) @(negedge clk);
    chk("busy_before_rst", busy[0], 1);
    abort[0] = 1'b1;
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("rst_midframe_outputs", {cs[0], dck[0], dat[0], busy[0], fd[0], rdy[0]}, 6'b110001);
    send(0, 8'h80, 16'h0800, 1);
    wait_idle(0);

    repeat (5) @(negedge clk);
    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);
    for (int g = 0; g < 2; g++) begin
      chk("frame_done_count", fd_cnt[g], exp_fd[g]);
      chk("frame_done_single", fdbad[g], 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
